// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS decode-stage register file:
//   - default datapath width and register count
//   - encoding of the register-dump FSM states (IDLE / SEND / DONE)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int MIPS_DATA_W   = 32;
    localparam int MIPS_NUM_REGS = 32;

    localparam logic [1:0] DUMP_IDLE = 2'd0;
    localparam logic [1:0] DUMP_SEND = 2'd1;
    localparam logic [1:0] DUMP_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DUMP_IDLE,
        ST_SEND = DUMP_SEND,
        ST_DONE = DUMP_DONE
    } dump_state_t;

endpackage : mips_pkg

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Streams every register of the register file to the debug unit using a
// valid/ready handshake. The array is read through an index/data pair; the
// word is captured into o_dump_data on the loading edge, so it reflects the
// array contents before any write on that same edge and then stays stable
// while the consumer stalls.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   i_dump_start        : request a full dump (honoured only in IDLE)
//   i_dump_ready        : consumer accepts the current word
//   o_rd_idx            : array index of the word to load on the next edge
//   i_rd_word           : array contents at o_rd_idx (unbypassed)
//   o_dump_valid        : current word valid
//   o_dump_idx          : index of the current word
//   o_dump_data         : contents of the current word
//   o_dump_busy         : high in SEND and DONE
//   o_dump_done         : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module regfile_dump_fsm
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int NUM_REGS = MIPS_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_rd_idx,
    input  logic [DATA_W-1:0] i_rd_word,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_idx,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_busy,
    output logic              o_dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t state;

    // Word that will be loaded on the next edge: word 0 when starting from
    // IDLE, otherwise the successor of the word currently on offer. The
    // wrap past LAST_IDX is harmless because nothing is loaded then.
    assign o_rd_idx = (state == ST_IDLE) ? '0 : o_dump_idx + ADDR_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            o_dump_valid <= 1'b0;
            o_dump_busy  <= 1'b0;
            o_dump_done  <= 1'b0;
            o_dump_idx   <= '0;
            o_dump_data  <= '0;
        end else begin
            o_dump_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_dump_start) begin
                        state        <= ST_SEND;
                        o_dump_valid <= 1'b1;
                        o_dump_busy  <= 1'b1;
                        o_dump_idx   <= '0;
                        o_dump_data  <= i_rd_word;
                    end
                end
                ST_SEND: begin
                    // o_dump_valid is always high in SEND.
                    if (i_dump_ready) begin
                        if (o_dump_idx != LAST_IDX) begin
                            o_dump_idx  <= o_rd_idx;
                            o_dump_data <= i_rd_word;
                        end else begin
                            state        <= ST_DONE;
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_dump_busy <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    o_dump_valid <= 1'b0;
                    o_dump_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : regfile_dump_fsm

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-read-port register file for the MIPS decode stage.
//   - NUM_RD independent combinational read ports
//   - optional same-cycle write-to-read bypass (BYPASS)
//   - optional hard-wired zero register (ZERO_REG)
//   - handshaked dump engine streaming every register to the debug unit
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   i_write_enable  : write strobe
//   i_w_dir         : write address
//   i_w_data        : write data
//   i_rd_dir        : read addresses, port p at [p*ADDR_W +: ADDR_W]
//   o_rd_data       : read data, port p at [p*DATA_W +: DATA_W]
//   i_dump_start    : request a full dump
//   i_dump_ready    : debug unit accepts the current dump word
//   o_dump_valid    : dump word valid
//   o_dump_idx      : index of the current dump word
//   o_dump_data     : contents of the current dump word
//   o_dump_busy     : dump in progress (SEND or DONE)
//   o_dump_done     : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module register_file_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int NUM_REGS = MIPS_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_write_enable,
    input  logic [ADDR_W-1:0]        i_w_dir,
    input  logic [DATA_W-1:0]        i_w_data,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_dir,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    input  logic                     i_dump_start,
    input  logic                     i_dump_ready,
    output logic                     o_dump_valid,
    output logic [ADDR_W-1:0]        o_dump_idx,
    output logic [DATA_W-1:0]        o_dump_data,
    output logic                     o_dump_busy,
    output logic                     o_dump_done
);

    // Addresses at or above NUM_REGS exist only for non-power-of-2 depths.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(NUM_REGS);
    endfunction

    // Address 0 is read-only zero when the zero register is enabled.
    function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_ok;

    assign write_ok = i_write_enable && addr_in_range(i_w_dir)
                      && !addr_is_zero_reg(i_w_dir);

    // NOTE: the array is cleared on reset because software relies on a known
    // register state; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (write_ok) begin
            regs[i_w_dir] <= i_w_data;
        end
    end

    // Read ports: fully independent, zero latency.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_word;

        assign rd_addr = i_rd_dir[p*ADDR_W +: ADDR_W];

        // NOTE: rd_word gets a default before any branch so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            rd_word = '0;
            if (addr_in_range(rd_addr) && !addr_is_zero_reg(rd_addr)) begin
                // A matching in-range, non-zero write is always a real write,
                // so forwarding it here is exactly what the array shows next.
                if ((BYPASS != 0) && i_write_enable && (i_w_dir == rd_addr)) begin
                    rd_word = i_w_data;
                end else begin
                    rd_word = regs[rd_addr];
                end
            end
        end

        assign o_rd_data[p*DATA_W +: DATA_W] = rd_word;
    end

    // Dump engine reads the array directly (no bypass) so the captured word
    // is the value held before any write on the loading edge.
    logic [ADDR_W-1:0] dump_rd_idx;
    logic [DATA_W-1:0] dump_rd_word;

    assign dump_rd_word = addr_in_range(dump_rd_idx) ? regs[dump_rd_idx] : '0;

    regfile_dump_fsm #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dump (
        .clk          (clk),
        .rst          (rst),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_rd_idx     (dump_rd_idx),
        .i_rd_word    (dump_rd_word),
        .o_dump_valid (o_dump_valid),
        .o_dump_idx   (o_dump_idx),
        .o_dump_data  (o_dump_data),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
// Two instances share all inputs: one with bypass and 4 read ports, one
// without bypass and 2 read ports. A behavioural model (plain array plus a
// transaction-level view of the dump) provides every expected value.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 4;
    localparam int NUM_NB   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        w_dir = '0;
    logic [DATA_W-1:0]        w_data = '0;
    logic [NUM_RD*ADDR_W-1:0] rd_dir = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_NB*DATA_W-1:0] rd_data_nb;
    logic                     dump_start = 1'b0;
    logic                     dump_ready = 1'b0;

    logic              dump_valid, dump_busy, dump_done;
    logic [ADDR_W-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              nb_valid, nb_busy, nb_done;
    logic [ADDR_W-1:0] nb_idx;
    logic [DATA_W-1:0] nb_data;

    register_file_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .i_write_enable(we), .i_w_dir(w_dir), .i_w_data(w_data),
        .i_rd_dir(rd_dir), .o_rd_data(rd_data),
        .i_dump_start(dump_start), .i_dump_ready(dump_ready),
        .o_dump_valid(dump_valid), .o_dump_idx(dump_idx),
        .o_dump_data(dump_data), .o_dump_busy(dump_busy),
        .o_dump_done(dump_done)
    );

    register_file_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_NB), .BYPASS(0), .ZERO_REG(1)
    ) dut_nb (
        .clk(clk), .rst(rst),
        .i_write_enable(we), .i_w_dir(w_dir), .i_w_data(w_data),
        .i_rd_dir(rd_dir[NUM_NB*ADDR_W-1:0]), .o_rd_data(rd_data_nb),
        .i_dump_start(dump_start), .i_dump_ready(dump_ready),
        .o_dump_valid(nb_valid), .o_dump_idx(nb_idx),
        .o_dump_data(nb_data), .o_dump_busy(nb_busy),
        .o_dump_done(nb_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [DATA_W-1:0] mdl [NUM_REGS];
    bit                m_active  = 1'b0;
    bit                m_in_done = 1'b0;
    int                m_idx     = 0;
    logic [DATA_W-1:0] m_word    = '0;

    function automatic logic [DATA_W-1:0] exp_read(input int addr, input bit bypass);
        if (addr == 0) return '0;
        if (bypass && we && int'(w_dir) == addr) return w_data;
        return mdl[addr];
    endfunction

    task automatic check_reads();
        for (int p = 0; p < NUM_RD; p++) begin
            int a;
            a = int'(rd_dir[p*ADDR_W +: ADDR_W]);
            check($sformatf("rd_byp_p%0d_a%0d", p, a), rd_data[p*DATA_W +: DATA_W], exp_read(a, 1'b1));
        end
        for (int p = 0; p < NUM_NB; p++) begin
            int a;
            a = int'(rd_dir[p*ADDR_W +: ADDR_W]);
            check($sformatf("rd_nob_p%0d_a%0d", p, a), rd_data_nb[p*DATA_W +: DATA_W], exp_read(a, 1'b0));
        end
    endtask

    task automatic set_all_rd(input int addr);
        for (int p = 0; p < NUM_RD; p++) rd_dir[p*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    // One clock: update the model from the inputs sampled on the edge, then
    // compare the registered dump outputs just after the edge.
    task automatic tick();
        bit was_reset;
        @(posedge clk);
        was_reset = !rst;
        if (!rst) begin
            m_active = 1'b0; m_in_done = 1'b0; m_idx = 0; m_word = '0;
            for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        end else begin
            if (m_in_done) begin
                m_in_done = 1'b0;
            end else if (m_active) begin
                if (dump_ready) begin
                    if (m_idx < NUM_REGS - 1) begin
                        m_idx++;
                        m_word = mdl[m_idx];
                    end else begin
                        m_active  = 1'b0;
                        m_in_done = 1'b1;
                    end
                end
            end else if (dump_start) begin
                m_active = 1'b1; m_idx = 0; m_word = mdl[0];
            end
            if (we && w_dir != '0) mdl[w_dir] = w_data;
        end
        #1;
        check("dump_valid", dump_valid, m_active);
        check("dump_busy", dump_busy, m_active || m_in_done);
        check("dump_done", dump_done, m_in_done);
        check("nb_dump_valid", nb_valid, m_active);
        check("nb_dump_busy", nb_busy, m_active || m_in_done);
        check("nb_dump_done", nb_done, m_in_done);
        if (m_active) begin
            check("dump_idx", dump_idx, m_idx);
            check("dump_data", dump_data, m_word);
            check("nb_dump_idx", nb_idx, m_idx);
            check("nb_dump_data", nb_data, m_word);
        end
        if (was_reset) begin
            check("rst_dump_idx", dump_idx, 0);
            check("rst_dump_data", dump_data, 0);
        end
    endtask

    int                acc_idx [$];
    logic [DATA_W-1:0] acc_data [$];
    int                done_cnt;
    bit                done_timing_ok;

    // Drain the current dump, optionally stalling every other cycle.
    task automatic run_dump(input bit alternate);
        int cyc;
        bit last_acc;
        cyc = 0;
        acc_idx.delete();
        acc_data.delete();
        done_cnt = 0;
        done_timing_ok = 1'b0;
        while ((m_active || m_in_done) && cyc < 200) begin
            dump_ready = alternate ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            last_acc = 1'b0;
            if (m_active && dump_ready) begin
                acc_idx.push_back(int'(dump_idx));
                acc_data.push_back(dump_data);
                last_acc = (m_idx == NUM_REGS - 1);
            end
            tick();
            if (dump_done) begin
                done_cnt++;
                if (last_acc) done_timing_ok = 1'b1;
            end
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_finished_busy", dump_busy, 0);
    endtask

    // Hold ready high until the given word is on offer.
    task automatic advance_to_word(input int target);
        int n;
        n = 0;
        dump_ready = 1'b1;
        while (!(m_active && m_idx == target) && n < 100) begin
            tick();
            n++;
        end
        dump_ready = 1'b0;
        check("reach_word_idx", dump_idx, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;

        // Reset for one cycle, then sweep every address on every port.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_valid", dump_valid, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_done", dump_done, 0);
        for (int a = 0; a < NUM_REGS; a++) begin
            for (int p = 0; p < NUM_RD; p++) rd_dir[p*ADDR_W +: ADDR_W] = ADDR_W'((a + p) % NUM_REGS);
            @(negedge clk);
            check_reads();
            check("rst_read_p0", rd_data[DATA_W-1:0], 0);
            tick();
        end

        // Write then read, no bypass involved.
        we = 1'b1; w_dir = 5'd5; w_data = 32'hDEADBEEF;
        set_all_rd(6);
        tick();
        we = 1'b0;
        set_all_rd(5);
        @(negedge clk);
        check_reads();
        for (int p = 0; p < NUM_RD; p++) check($sformatf("wr5_p%0d", p), rd_data[p*DATA_W +: DATA_W], 32'hDEADBEEF);
        for (int p = 0; p < NUM_NB; p++) check($sformatf("wr5_nb_p%0d", p), rd_data_nb[p*DATA_W +: DATA_W], 32'hDEADBEEF);
        tick();

        // Write to register 0 is dropped, bypass suppressed for address 0.
        we = 1'b1; w_dir = 5'd0; w_data = 32'h1234;
        set_all_rd(0);
        @(negedge clk);
        check("zero_byp", rd_data[DATA_W-1:0], 0);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("zero_after", rd_data[DATA_W-1:0], 0);
        check("zero_after_nb", rd_data_nb[DATA_W-1:0], 0);
        tick();

        // Bypass vs. no bypass on port 1.
        we = 1'b1; w_dir = 5'd7; w_data = 32'h11111111;
        tick();
        w_data = 32'hA5A5A5A5;
        set_all_rd(3);
        rd_dir[1*ADDR_W +: ADDR_W] = 5'd7;
        @(negedge clk);
        check_reads();
        check("bypass_on_p1", rd_data[1*DATA_W +: DATA_W], 32'hA5A5A5A5);
        check("bypass_off_p1", rd_data_nb[1*DATA_W +: DATA_W], 32'h11111111);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("bypass_off_next", rd_data_nb[1*DATA_W +: DATA_W], 32'hA5A5A5A5);
        tick();

        // Randomized reads and writes against the model.
        for (int c = 0; c < 300; c++) begin
            we     = ($urandom_range(0, 3) != 0);
            w_dir  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            w_data = $urandom;
            for (int p = 0; p < NUM_RD; p++) begin
                int a;
                a = $urandom_range(0, NUM_REGS - 1);
                if ($urandom_range(0, 3) == 0) a = int'(w_dir);
                if ($urandom_range(0, 15) == 0) a = 0;
                rd_dir[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
            end
            @(negedge clk);
            check_reads();
            tick();
        end
        we = 1'b0;

        // Preload register i with i*3, then dump with backpressure.
        for (int i = 0; i < NUM_REGS; i++) begin
            we = 1'b1; w_dir = ADDR_W'(i); w_data = DATA_W'(i * 3);
            tick();
        end
        we = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("bp_first_idx", dump_idx, 0);
        run_dump(1'b1);
        check("bp_word_count", acc_idx.size(), NUM_REGS);
        for (int k = 0; k < acc_idx.size(); k++) begin
            check($sformatf("bp_idx_%0d", k), acc_idx[k], k);
            check($sformatf("bp_data_%0d", k), acc_data[k], k * 3);
        end
        check("bp_done_pulses", done_cnt, 1);
        check("bp_done_timing", done_timing_ok, 1);

        // Concurrent writes while word 3 is stalled; second start ignored.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        advance_to_word(3);
        we = 1'b1; w_dir = 5'd3; w_data = 32'hFFFF;
        @(negedge clk);
        check("cw_w3_before", dump_data, 9);
        tick();
        w_dir = 5'd10;
        dump_start = 1'b1;
        tick();
        we = 1'b0;
        dump_start = 1'b0;
        tick();
        check("cw_w3_hold", dump_data, 9);
        check("cw_w3_idx", dump_idx, 3);
        run_dump(1'b0);
        check("cw_word_count", acc_idx.size(), NUM_REGS - 3);
        if (acc_idx.size() == NUM_REGS - 3) begin
            check("cw_w3_idx_acc", acc_idx[0], 3);
            check("cw_w3_data_acc", acc_data[0], 9);
            check("cw_w10_idx_acc", acc_idx[7], 10);
            check("cw_w10_data_acc", acc_data[7], 32'hFFFF);
            check("cw_w31_idx_acc", acc_idx[NUM_REGS-4], 31);
        end
        check("cw_done_pulses", done_cnt, 1);
        tick();
        check("cw_no_restart", dump_valid, 0);
        set_all_rd(3);
        @(negedge clk);
        check("cw_reg3_read", rd_data[DATA_W-1:0], 32'hFFFF);
        tick();

        // Reset mid-dump at word 12.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        advance_to_word(12);
        rst = 1'b0;
        dump_ready = 1'b1;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", dump_valid, 0);
        check("mid_rst_busy", dump_busy, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_rst_no_done", dump_done, 0);
        end
        dump_ready = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            for (int p = 0; p < NUM_RD; p++) rd_dir[p*ADDR_W +: ADDR_W] = ADDR_W'((a + 7 * p) % NUM_REGS);
            @(negedge clk);
            check_reads();
            check("mid_rst_read_p0", rd_data[DATA_W-1:0], 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_mp
